// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game: state encoding, sprite and screen geometry.
// Also hosts the BCD increment helper used by the score counter.
package flappy_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BIRD_X   = 100;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int FLOOR_Y  = 470;

  function automatic logic [15:0] bcd_add1(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bird_physics_ctrl_bcd.sv
// Four-digit BCD score register; clear wins over increment, 9999 wraps to 0000.
module bcd_counter4
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 16'h0000;
    end else if (clear) begin
      value <= 16'h0000;
    end else if (inc) begin
      value <= bcd_add1(value);
    end
  end

endmodule

// File: rtl/bird_physics_ctrl.sv
// Frame-tick driven game FSM and bird motion engine.
// Flap and collide events are latched between ticks so none are lost.
module bird_physics_ctrl
  import flappy_pkg::*;
#(
  parameter int BIRD_Y0    = 220,
  parameter int FLAP_V     = 6,
  parameter int MAX_FALL_V = 8,
  parameter int GRAV_DIV   = 3,
  parameter int TICK_LINE  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        start_button,
  input  logic        flap_button,
  input  logic        collide,
  input  logic        pipe_passed,
  output logic [9:0]  bird_y,
  output logic        pipe_run_en,
  output logic [1:0]  game_state,
  output logic [15:0] score
);

  localparam logic [9:0]        Y_START = 10'(BIRD_Y0);
  localparam logic [9:0]        Y_FLOOR = 10'(FLOOR_Y - SPRITE_H);
  localparam logic signed [11:0] Y_LIMIT = 12'(FLOOR_Y - SPRITE_H);
  localparam logic signed [7:0] V_FLAP  = 8'(FLAP_V);
  localparam logic signed [7:0] V_MAX   = 8'(MAX_FALL_V);
  localparam logic [7:0]        G_LAST  = 8'(GRAV_DIV - 1);
  localparam logic [9:0]        T_LINE  = 10'(TICK_LINE);

  logic               tick_cond, tick_cond_q, tick;
  logic               flap_q, start_q, flap_rise, start_rise;
  logic               flap_pending, hit_latch;
  logic               flap_now, hit_now, playing;
  logic               grav_step, floor_hit;
  logic [1:0]         state, state_n;
  logic signed [7:0]  vel, vel_n, vel_grav, vel_cand;
  logic [7:0]         grav_cnt, grav_n;
  logic [9:0]         y_n;
  logic signed [11:0] y_sum;
  logic               score_clear, score_inc;

  assign tick_cond  = (hCount == 10'd0) && (vCount == T_LINE);
  assign tick       = tick_cond & ~tick_cond_q;
  assign flap_rise  = flap_button & ~flap_q;
  assign start_rise = start_button & ~start_q;
  assign playing    = (state == ST_PLAYING);

  // Same-cycle events must count, so fold the live inputs into the latches.
  assign flap_now  = flap_pending | flap_rise;
  assign hit_now   = hit_latch | (collide & playing);
  assign grav_step = (grav_cnt == G_LAST);

  always_comb begin
    vel_grav  = vel + (grav_step ? 8'sd1 : 8'sd0);
    vel_cand  = flap_now ? -V_FLAP
              : ((vel_grav > V_MAX) ? V_MAX : vel_grav);
    y_sum     = $signed({2'b00, bird_y})
              + $signed({{4{vel_cand[7]}}, vel_cand});
    floor_hit = (y_sum > Y_LIMIT);
  end

  always_comb begin
    state_n = state;
    y_n     = bird_y;
    vel_n   = vel;
    grav_n  = grav_cnt;
    unique case (1'b1)
      state == ST_IDLE: begin
        y_n    = Y_START;
        vel_n  = 8'sd0;
        grav_n = 8'd0;
        if (start_rise) state_n = ST_PLAYING;
      end
      state == ST_PLAYING: begin
        if (tick) begin
          grav_n = (flap_now || grav_step) ? 8'd0 : grav_cnt + 8'd1;
          if (y_sum[11]) begin
            y_n   = 10'd0;
            vel_n = 8'sd0;
          end else begin
            y_n   = y_sum[9:0];
            vel_n = vel_cand;
          end
          if (floor_hit) begin
            y_n     = Y_FLOOR;
            state_n = ST_DEAD;
          end else if (hit_now) begin
            state_n = ST_DEAD;
          end
        end
      end
      default: begin
        if (start_rise) begin
          state_n = ST_IDLE;
          y_n     = Y_START;
          vel_n   = 8'sd0;
          grav_n  = 8'd0;
        end
      end
    endcase
  end

  assign score_clear = (state == ST_IDLE) & start_rise;
  assign score_inc   = playing & pipe_passed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bird_y       <= Y_START;
      vel          <= 8'sd0;
      grav_cnt     <= 8'd0;
      pipe_run_en  <= 1'b0;
      flap_pending <= 1'b0;
      hit_latch    <= 1'b0;
      tick_cond_q  <= 1'b0;
      flap_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state        <= state_n;
      bird_y       <= y_n;
      vel          <= vel_n;
      grav_cnt     <= grav_n;
      pipe_run_en  <= (state_n == ST_PLAYING);
      flap_pending <= tick ? 1'b0 : (flap_pending | flap_rise);
      hit_latch    <= tick ? 1'b0 : (hit_latch | (collide & playing));
      tick_cond_q  <= tick_cond;
      flap_q       <= flap_button;
      start_q      <= start_button;
    end
  end

  assign game_state = state;

  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .value (score)
  );

endmodule

// File: tb/tb_bird_physics_ctrl.sv
// Bench for bird_physics_ctrl: directed scenarios plus random play,
// all outputs compared every cycle against an integer game model.
module tb_bird_physics_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hCount, vCount;
  logic        start_button, flap_button, collide, pipe_passed;
  logic [9:0]  bird_y;
  logic        pipe_run_en;
  logic [1:0]  game_state;
  logic [15:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_y, m_vel, m_g, m_score;
  int m_fp, m_hit, m_tcq, m_fq, m_sq;

  bird_physics_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .hCount       (hCount),
    .vCount       (vCount),
    .start_button (start_button),
    .flap_button  (flap_button),
    .collide      (collide),
    .pipe_passed  (pipe_passed),
    .bird_y       (bird_y),
    .pipe_run_en  (pipe_run_en),
    .game_state   (game_state),
    .score        (score)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int s);
    return ((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256
         + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  task automatic model_reset();
    m_st = 0; m_y = 220; m_vel = 0; m_g = 0; m_score = 0;
    m_fp = 0; m_hit = 0; m_tcq = 0; m_fq = 0; m_sq = 0;
  endtask

  // Game rules in plain integer arithmetic, one call per clock.
  task automatic model_step(input int h, input int v, input int st,
                            input int fl, input int co, input int pp);
    int tc, tk, fr, sr, play, fe, he, nv, ys;
    tc   = (h == 0 && v == 480);
    tk   = tc && !m_tcq;
    fr   = fl && !m_fq;
    sr   = st && !m_sq;
    play = (m_st == 1);
    fe   = m_fp || fr;
    he   = m_hit || (co && play);
    if (m_st == 0) begin
      m_y = 220; m_vel = 0; m_g = 0;
      if (sr) begin m_st = 1; m_score = 0; end
    end else if (m_st == 1) begin
      if (pp) m_score = (m_score + 1) % 10000;
      if (tk) begin
        if (fe) nv = -6;
        else begin
          nv = m_vel + ((m_g == 2) ? 1 : 0);
          if (nv > 8) nv = 8;
        end
        m_g = fe ? 0 : (m_g + 1) % 3;
        ys  = m_y + nv;
        if (ys < 0) begin m_y = 0; m_vel = 0; end
        else begin m_y = ys; m_vel = nv; end
        if (ys + 16 > 470) begin m_y = 454; m_st = 2; end
        else if (he) m_st = 2;
      end
    end else begin
      if (sr) begin m_st = 0; m_y = 220; m_vel = 0; m_g = 0; end
    end
    m_fp  = tk ? 0 : (m_fp || fr);
    m_hit = tk ? 0 : (m_hit || (co && play));
    m_tcq = tc; m_fq = fl; m_sq = st;
  endtask

  task automatic chk_all();
    chk("bird_y", 32'(bird_y), m_y);
    chk("state", 32'(game_state), m_st);
    chk("score", 32'(score), to_bcd(m_score));
    chk("run_en", 32'(pipe_run_en), (m_st == 1) ? 1 : 0);
  endtask

  task automatic cyc(input int h, input int v, input logic st,
                     input logic fl, input logic co, input logic pp);
    hCount = 10'(h); vCount = 10'(v);
    start_button = st; flap_button = fl;
    collide = co; pipe_passed = pp;
    model_step(h, v, st, fl, co, pp);
    @(posedge clk); #1;
    chk_all();
  endtask

  task automatic nt(input logic st, input logic fl, input logic co,
                    input logic pp);
    cyc($urandom_range(1, 799), $urandom_range(0, 524), st, fl, co, pp);
  endtask

  // mode 0 idle, 1 flap pulse early, 2 flap held, 3 flap rises on the tick
  task automatic frame(input int mode);
    int n, k;
    n = 3 + $urandom_range(0, 2);
    k = 1 + $urandom_range(0, 2);
    for (int i = 0; i < n; i++)
      nt(1'b0, (mode == 1 && i < 2) || mode == 2, 1'b0, 1'b0);
    for (int j = 0; j < k; j++)
      cyc(0, 480, 1'b0, mode == 2 || mode == 3, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    nt(1'b1, 1'b0, 1'b0, 1'b0);
    nt(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int guard, yb;
    reset = 1'b1;
    hCount = 10'd1; vCount = 10'd0;
    start_button = 1'b0; flap_button = 1'b0;
    collide = 1'b0; pipe_passed = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_y", 32'(bird_y), 220);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_run_en", 32'(pipe_run_en), 0);

    press_start();
    chk("start_state", 32'(game_state), 1);
    repeat (6) frame(0);
    chk("grav_6ticks", 32'(bird_y), 225);

    guard = 0;
    while (m_y < 300 && guard < 100) begin frame(0); guard++; end
    chk("y_ge_300", 32'(bird_y >= 10'd300), 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_y", 32'(bird_y), 220);
    chk("mid_rst_state", 32'(game_state), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_run_en", 32'(pipe_run_en), 0);
    @(posedge clk); #1 reset = 1'b0;

    press_start();
    repeat (999) nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_0999", 32'(score), 32'h0999);
    nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_1000", 32'(score), 32'h1000);
    repeat (8999) nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_9999", 32'(score), 32'h9999);
    nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_wrap", 32'(score), 32'h0000);

    guard = 0;
    while (m_y > 0 && m_st == 1 && guard < 100) begin frame(1); guard++; end
    chk("ceil_y", 32'(bird_y), 0);
    chk("ceil_state", 32'(game_state), 1);

    guard = 0;
    while (m_y < 100 && m_st == 1 && guard < 100) begin frame(0); guard++; end
    repeat (3) nt(1'b0, 1'b0, 1'b0, 1'b0);
    yb = m_y;
    cyc(0, 480, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flap_at_tick", 32'(bird_y), yb - 6);
    repeat (10) frame(2);

    repeat (3) nt(1'b0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (m_st == 1 && guard < 200) begin frame(0); guard++; end
    chk("floor_y", 32'(bird_y), 454);
    chk("floor_state", 32'(game_state), 2);
    chk("floor_run_en", 32'(pipe_run_en), 0);

    repeat (3) nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dead_pp", 32'(score), 32'h0003);
    press_start();
    chk("idle_state", 32'(game_state), 0);
    chk("idle_score_held", 32'(score), 32'h0003);
    repeat (2) nt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_pp", 32'(score), 32'h0003);
    press_start();
    chk("replay_score", 32'(score), 32'h0000);
    chk("replay_run_en", 32'(pipe_run_en), 1);

    repeat (2) nt(1'b0, 1'b0, 1'b0, 1'b0);
    nt(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) nt(1'b0, 1'b0, 1'b0, 1'b0);
    chk("collide_wait", 32'(game_state), 1);
    cyc(0, 480, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("collide_dead", 32'(game_state), 2);
    chk("death_pp", 32'(score), 32'h0001);

    press_start();
    press_start();
    for (int f = 0; f < 400; f++) begin
      int n, k;
      n = 3 + $urandom_range(0, 3);
      k = 1 + $urandom_range(0, 2);
      for (int i = 0; i < n; i++)
        nt($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
      for (int j = 0; j < k; j++)
        cyc(0, 480, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
